// File: rtl/cache_refill_engine_if.sv
// rtl/cache_refill_engine_if.sv - miss, memory and fill handshake bundle for the refill engine
interface cache_refill_engine_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int BLOCK_SIZE    = 32
);
    logic                     miss_valid;
    logic                     miss_ready;
    logic [ADDRESS_WIDTH-1:0] miss_addr;
    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic [ADDRESS_WIDTH-1:0] mem_req_addr;
    logic                     mem_rdata_valid;
    logic [DATA_WIDTH-1:0]    mem_rdata;
    logic                     crit_valid;
    logic [DATA_WIDTH-1:0]    crit_data;
    logic                     fill_valid;
    logic                     fill_ready;
    logic [ADDRESS_WIDTH-1:0] fill_addr;
    logic [BLOCK_SIZE*8-1:0]  fill_line;
    logic                     busy;

    // Engine side
    modport slave (
        input  miss_valid, miss_addr, mem_req_ready, mem_rdata_valid, mem_rdata, fill_ready,
        output miss_ready, mem_req_valid, mem_req_addr, crit_valid, crit_data,
        output fill_valid, fill_addr, fill_line, busy
    );

    // Controller / memory side
    modport master (
        output miss_valid, miss_addr, mem_req_ready, mem_rdata_valid, mem_rdata, fill_ready,
        input  miss_ready, mem_req_valid, mem_req_addr, crit_valid, crit_data,
        input  fill_valid, fill_addr, fill_line, busy
    );
endinterface

// File: rtl/cache_refill_engine.sv
// rtl/cache_refill_engine.sv - critical-word-first wrapping burst refill into a line buffer
module cache_refill_engine #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int BLOCK_SIZE    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    cache_refill_engine_if.slave bus
);
    localparam int NUM_BEATS = BLOCK_SIZE / (DATA_WIDTH / 8);
    localparam int BOFF      = $clog2(DATA_WIDTH / 8);
    localparam int LOFF      = $clog2(BLOCK_SIZE);
    localparam int IW        = (LOFF > BOFF) ? (LOFF - BOFF) : 1;

    localparam logic [IW-1:0]            LAST_IDX  = IW'(NUM_BEATS - 1);
    localparam logic [ADDRESS_WIDTH-1:0] WORD_MASK = {ADDRESS_WIDTH{1'b1}} << BOFF;
    localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK = {ADDRESS_WIDTH{1'b1}} << LOFF;

    typedef enum logic [1:0] {IDLE, REQ, BEATS, FILL} state_t;

    state_t        state;
    logic [IW-1:0] crit_idx;
    logic [IW-1:0] beat_cnt;
    logic [IW-1:0] wr_idx;

    // Masking keeps the wrap a pure index overflow, even for single-beat lines
    assign wr_idx         = (crit_idx + beat_cnt) & LAST_IDX;
    assign bus.miss_ready = (state == IDLE) && !reset;
    assign bus.busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            crit_idx          <= '0;
            beat_cnt          <= '0;
            bus.mem_req_valid <= 1'b0;
            bus.mem_req_addr  <= '0;
            bus.crit_valid    <= 1'b0;
            bus.crit_data     <= '0;
            bus.fill_valid    <= 1'b0;
            bus.fill_addr     <= '0;
            bus.fill_line     <= '0;
        end else begin
            bus.crit_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.miss_valid) begin
                        crit_idx          <= IW'(bus.miss_addr >> BOFF) & LAST_IDX;
                        beat_cnt          <= '0;
                        bus.mem_req_addr  <= bus.miss_addr & WORD_MASK;
                        bus.fill_addr     <= bus.miss_addr & LINE_MASK;
                        bus.mem_req_valid <= 1'b1;
                        state             <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        bus.mem_req_valid <= 1'b0;
                        beat_cnt          <= '0;
                        state             <= BEATS;
                    end
                end
                BEATS: begin
                    if (bus.mem_rdata_valid) begin
                        bus.fill_line[int'(wr_idx) * DATA_WIDTH +: DATA_WIDTH] <= bus.mem_rdata;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == '0) begin
                            bus.crit_data  <= bus.mem_rdata;
                            bus.crit_valid <= 1'b1;
                        end
                        if (beat_cnt == LAST_IDX) begin
                            bus.fill_valid <= 1'b1;
                            state          <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (bus.fill_ready) begin
                        bus.fill_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_refill_engine.sv
// tb/tb_cache_refill_engine.sv - vector table, corner sequences and random refills for cache_refill_engine
module tb_cache_refill_engine;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BS = 32;
    localparam int NB = BS / (DW / 8);
    localparam int LW = BS * 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_refill_engine_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(BS)) bus ();

    cache_refill_engine #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(BS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        int            req_wait;
        logic [7:0]    gaps;
        int            fill_wait;
        bit            spurious;
        bit            hold_next;
        logic [AW-1:0] exp_req;
        logic [AW-1:0] exp_fill;
        int            exp_crit;
        int            exp_lat;
    } vec_t;

    vec_t          vecs[7];
    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] beat_data[NB];
    logic [LW-1:0] prev_line;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Beat k of a wrapping burst lands in word (crit + k) mod NB
    function automatic logic [LW-1:0] model_line(input int crit);
        logic [LW-1:0] l = '0;
        for (int k = 0; k < NB; k++) l[((crit + k) % NB) * DW +: DW] = beat_data[k];
        return l;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_miss_ready"}, bus.miss_ready, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_mem_req_valid"}, bus.mem_req_valid, 0);
        chk({tag, "_mem_req_addr"}, bus.mem_req_addr, 0);
        chk({tag, "_crit_valid"}, bus.crit_valid, 0);
        chk({tag, "_crit_data"}, bus.crit_data, 0);
        chk({tag, "_fill_valid"}, bus.fill_valid, 0);
        chk({tag, "_fill_addr"}, bus.fill_addr, 0);
        chk({tag, "_fill_line"}, bus.fill_line, 0);
    endtask

    task automatic refill(input logic [AW-1:0] addr, input int req_wait, input logic [7:0] gaps,
                          input int fill_wait, input bit spurious, input bit hold_next,
                          input logic [AW-1:0] next_addr, input logic [AW-1:0] exp_req,
                          input logic [AW-1:0] exp_fill, input int exp_crit, input int exp_lat);
        int            lat;
        logic [LW-1:0] exp_line;
        for (int k = 0; k < NB; k++) beat_data[k] = $urandom;
        exp_line = model_line(exp_crit);
        if (spurious) begin
            bus.mem_rdata_valid = 1'b1;
            bus.mem_rdata       = $urandom;
            @(negedge clk);
            bus.mem_rdata_valid = 1'b0;
            chk("idle_spur_crit", bus.crit_valid, 0);
            chk("idle_spur_line", bus.fill_line, prev_line);
        end
        chk("idle_ready", bus.miss_ready, 1);
        chk("idle_busy", bus.busy, 0);
        bus.miss_valid = 1'b1;
        bus.miss_addr  = addr;
        @(negedge clk);
        lat = 1;
        bus.miss_valid = 1'b0;
        for (int w = 0; w <= req_wait; w++) begin
            chk("req_valid", bus.mem_req_valid, 1);
            chk("req_addr", bus.mem_req_addr, exp_req);
            chk("req_busy", bus.busy, 1);
            chk("req_crit_quiet", bus.crit_valid, 0);
            bus.mem_req_ready = (w == req_wait);
            if (spurious) begin
                bus.mem_rdata_valid = 1'b1;
                bus.mem_rdata       = $urandom;
            end
            @(negedge clk);
            lat++;
        end
        bus.mem_req_ready   = 1'b0;
        bus.mem_rdata_valid = 1'b0;
        if (hold_next) begin
            bus.miss_valid = 1'b1;
            bus.miss_addr  = next_addr;
        end
        for (int k = 0; k < NB; k++) begin
            chk("beat_req_low", bus.mem_req_valid, 0);
            chk("beat_fill_low", bus.fill_valid, 0);
            if (hold_next) chk("beat_reject", bus.miss_ready, 0);
            bus.mem_rdata_valid = 1'b1;
            bus.mem_rdata       = beat_data[k];
            @(negedge clk);
            lat++;
            bus.mem_rdata_valid = 1'b0;
            chk("crit_valid", bus.crit_valid, (k == 0));
            if (k == 0) chk("crit_data", bus.crit_data, beat_data[0]);
            if (k < NB - 1 && gaps[k]) begin
                @(negedge clk);
                lat++;
                chk("gap_crit", bus.crit_valid, 0);
            end
        end
        chk("fill_latency", lat, exp_lat);
        for (int w = 0; w <= fill_wait; w++) begin
            chk("fill_valid", bus.fill_valid, 1);
            chk("fill_addr", bus.fill_addr, exp_fill);
            chk("fill_line", bus.fill_line, exp_line);
            chk("fill_crit_quiet", bus.crit_valid, 0);
            chk("fill_req_low", bus.mem_req_valid, 0);
            if (hold_next) chk("fill_reject", bus.miss_ready, 0);
            bus.fill_ready = (w == fill_wait);
            @(negedge clk);
        end
        bus.fill_ready = 1'b0;
        chk("fill_done", bus.fill_valid, 0);
        prev_line = exp_line;
    endtask

    initial begin
        logic [AW-1:0] ra;
        int            rw;
        int            fw;
        logic [7:0]    rg;

        reset               = 1'b1;
        bus.miss_valid      = 1'b0;
        bus.miss_addr       = '0;
        bus.mem_req_ready   = 1'b0;
        bus.mem_rdata_valid = 1'b0;
        bus.mem_rdata       = '0;
        bus.fill_ready      = 1'b0;
        prev_line           = '0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        reset = 1'b0;
        @(negedge clk);
        chk("por_ready_after", bus.miss_ready, 1);

        //          addr          rw gaps   fw sp hn exp_req       exp_fill      crit lat
        vecs[0] = '{32'h0000_1234, 0, 8'h00, 0, 0, 0, 32'h0000_1234, 32'h0000_1220, 5, 10};
        vecs[1] = '{32'h0000_203C, 0, 8'h00, 0, 0, 0, 32'h0000_203C, 32'h0000_2020, 7, 10};
        vecs[2] = '{32'h0000_5008, 3, 8'h24, 4, 0, 0, 32'h0000_5008, 32'h0000_5000, 2, 15};
        vecs[3] = '{32'h0000_9FE1, 2, 8'h00, 0, 1, 0, 32'h0000_9FE0, 32'h0000_9FE0, 0, 12};
        vecs[4] = '{32'h0000_0777, 0, 8'h00, 2, 0, 1, 32'h0000_0774, 32'h0000_0760, 5, 10};
        vecs[5] = '{32'hFFFF_FFFF, 1, 8'h41, 1, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFE0, 7, 13};
        vecs[6] = '{32'h0000_0010, 0, 8'h7F, 0, 1, 0, 32'h0000_0010, 32'h0000_0000, 4, 17};

        for (int i = 0; i < 7; i++) begin
            refill(vecs[i].addr, vecs[i].req_wait, vecs[i].gaps, vecs[i].fill_wait,
                   vecs[i].spurious, vecs[i].hold_next, (i < 6) ? vecs[i + 1].addr : '0,
                   vecs[i].exp_req, vecs[i].exp_fill, vecs[i].exp_crit, vecs[i].exp_lat);
        end

        // Reset in the middle of a burst, with memory still streaming afterwards
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 32'h0000_1100;
        @(negedge clk);
        bus.miss_valid    = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.mem_rdata_valid = 1'b1;
            bus.mem_rdata       = $urandom;
            if (k == 4) reset = 1'b1;
            @(negedge clk);
        end
        chk_reset_outputs("midrst");
        reset = 1'b0;
        for (int k = 5; k < NB; k++) begin
            bus.mem_rdata = $urandom;
            @(negedge clk);
            chk("post_rst_crit", bus.crit_valid, 0);
            chk("post_rst_line", bus.fill_line, 0);
            chk("post_rst_busy", bus.busy, 0);
        end
        bus.mem_rdata_valid = 1'b0;
        prev_line = '0;
        refill(32'h0000_0040, 0, 8'h00, 0, 0, 0, '0, 32'h0000_0040, 32'h0000_0040, 0, 10);

        for (int n = 0; n < 25; n++) begin
            ra = $urandom;
            rw = $urandom_range(0, 3);
            fw = $urandom_range(0, 3);
            rg = 8'($urandom_range(0, 127));
            refill(ra, rw, rg, fw, bit'($urandom_range(0, 1)), 1'b0, '0,
                   ra & ~32'h3, ra & ~32'h1F, int'(ra % 32) / 4, NB + 2 + rw + $countones(rg[6:0]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_refill_engine.md
# cache_refill_engine

Miss-refill stage directly downstream of the cache controller's MISS state. It accepts one miss request at a time, issues a critical-word-first wrapping burst read to main memory, and forwards the critical word to the CPU path as soon as it arrives. It assembles the full block in a line buffer, then presents the complete line to the controller for the ALLOCATE step into the victim way.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, byte address width
- DATA_WIDTH, 32, memory beat width in bits (multiple of 8)
- BLOCK_SIZE, 32, cache block size in bytes (power of two, ≥ DATA_WIDTH/8)
- Derived: BEATS = BLOCK_SIZE/(DATA_WIDTH/8); BOFF = log2(DATA_WIDTH/8); LOFF = log2(BLOCK_SIZE)

Ports:
- clk  in  1  clock; all logic rises on posedge
- reset  in  1  synchronous, active-high reset
- miss_valid  in  1  controller requests a refill
- miss_ready  out  1  engine idle, accepts request
- miss_addr  in  ADDRESS_WIDTH  byte address of the missing access
- mem_req_valid  out  1  burst read request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDRESS_WIDTH  word-aligned critical address (miss_addr, low BOFF bits cleared)
- mem_rdata_valid  in  1  one beat valid
- mem_rdata  in  DATA_WIDTH  beat data
- crit_valid  out  1  one-cycle pulse: critical word available
- crit_data  out  DATA_WIDTH  critical word
- fill_valid  out  1  complete line ready for allocation
- fill_ready  in  1  controller/way consumes line
- fill_addr  out  ADDRESS_WIDTH  block-aligned address (low LOFF bits zero)
- fill_line  out  BLOCK_SIZE*8  assembled line; word w at bits [w*DATA_WIDTH +: DATA_WIDTH]
- busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, REQ, BEATS, FILL.
- IDLE: miss_ready=1. On miss_valid&&miss_ready, latch addr and crit_idx = miss_addr[LOFF-1:BOFF]. Next state is REQ.
- REQ: mem_req_valid=1 with a stable mem_req_addr until mem_req_ready is high. Handshake cycle sets beat_cnt=0. Next state is BEATS.
- BEATS: each cycle with mem_rdata_valid writes mem_rdata to word index (crit_idx+beat_cnt) mod BEATS and increments beat_cnt. Index wrap is a natural LOFF-BOFF bit overflow. Gaps (mem_rdata_valid=0) are allowed and hold state. The beat at beat_cnt=BEATS-1 moves to FILL.
- Beat 0 additionally registers crit_data and pulses crit_valid for exactly one cycle.
- FILL: fill_valid=1; fill_line and fill_addr are held stable until fill_ready. The handshake cycle returns to IDLE.
- mem_rdata_valid outside BEATS is ignored: no buffer write, no crit pulse.
- miss_valid outside IDLE is not accepted (miss_ready=0). The next request can be accepted in the cycle after the fill handshake.
- Line buffer is not cleared between misses. All words are overwritten in every refill.

## Timing
- Reset (sync, high) forces IDLE. Reset values: miss_ready=0 during reset and 1 in the first cycle after. mem_req_valid=0, crit_valid=0, fill_valid=0, busy=0, crit_data=0, fill_addr=0, mem_req_addr=0, fill_line=0.
- Reset mid-operation (any state) aborts the refill in the next cycle. A pending fill_valid drops and the partial line is discarded. Memory beats arriving after reset are ignored.
- Acceptance at edge t gives mem_req_valid=1 from cycle t+1. With mem_req_ready=1 at t+1, BEATS starts at t+2.
- Beat 0 sampled at edge e gives crit_valid=1 in cycle e+1 only.
- Last beat sampled at edge e gives fill_valid=1 from cycle e+1.
- Minimum miss-accept to fill_valid latency is BEATS+2 cycles (1 REQ + BEATS + 1 registration).
- Outputs are registered except miss_ready and busy, which are decoded from the state register.

## Test plan
- Basic refill: miss_addr=0x0000_1234, memory ready immediately, beats D0..D7 back-to-back. Expect mem_req_addr=0x1234, crit_valid pulse with crit_data=D0, fill_addr=0x1220, and words 5,6,7,0,1,2,3,4 = D0..D7. fill_valid appears 10 cycles after acceptance.
- Aligned/wrap edge: miss_addr=0x0000_203C (crit_idx=7). Expect word7=D0 and word0..6=D1..D7, fill_addr=0x2020.
- Backpressure: mem_req_ready low 3 cycles, beat gaps after beats 2 and 5, fill_ready low 4 cycles. Expect mem_req_addr/fill_line stable throughout, a single crit pulse, and exactly one fill handshake.
- Busy rejection: second miss_valid asserted during BEATS and FILL. Expect miss_ready=0 and no second mem request. The second request is accepted the cycle after the fill handshake.
- Spurious data: mem_rdata_valid pulses while in IDLE and REQ. Expect no crit_valid, no buffer change, and the following refill line correct.
- Reset mid-burst: reset at beat 4 for 1 cycle, then a new miss to 0x0000_0040. Expect all outputs at reset values, and a new refill completing with the correct line and no leakage of the old words.
